fc_ctrl: RTL and testbench

Control FSM for the 16-bit fully-connected layer datapath (M=8 inputs, N=16 outputs, one MAC, ReLU in the datapath). It accepts an M-element input vector over a valid/ready handshake into the vector memory. It then sequences the weight ROM, the vector memory and the MAC accumulator to produce N outputs, one row at a time, and presents each result on a valid/ready output handshake. It drives no data; it generates addresses, write enables and accumulator controls only.

---
 rtl/fc_pkg.sv | 14 +
 rtl/fc_ctrl_mod_counter.sv | 36 +++
 rtl/fc_ctrl.sv | 120 ++++++++++++
 tb/tb_fc_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and default dimensions for the fully-connected layer control path.
package fc_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int FC_M = 8;
  localparam int FC_N = 16;

endpackage

// File: rtl/fc_ctrl_mod_counter.sv
// Modulo-MOD up counter with clear and increment, wraps to 0 after MOD-1.
// Registered count, single-cycle update; no backpressure of its own.
module mod_counter #(
  parameter int MOD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(MOD)-1:0]   cnt,
  output logic                     last
);

  logic [$clog2(MOD)-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == ($clog2(MOD))'(MOD - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + ($clog2(MOD))'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fc_ctrl.sv
// FC layer sequencer: loads M inputs, runs M MACs per row for N rows; result valid M+1 edges after issue start.
// Holds OUT with stable addresses until output_ready; input_ready only in LOAD.
module fc_ctrl
  import fc_pkg::*;
#(
  parameter int M = FC_M,
  parameter int N = FC_N
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       input_valid,
  output logic                       input_ready,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic                       wr_en_x,
  output logic [$clog2(M)-1:0]       addr_x,
  output logic [$clog2(M*N)-1:0]     addr_w,
  output logic                       clear_acc,
  output logic                       en_acc
);

  localparam int XW = $clog2(M);
  localparam int WW = $clog2(M*N);
  localparam int RW = $clog2(N);

  state_t          state_q, state_d;
  logic            en_q, en_d;
  logic [XW-1:0]   ld_cnt, col_cnt;
  logic [RW-1:0]   row_cnt;
  logic            ld_last, col_last, row_last;
  logic            accept, issue, out_hs, load_done;
  logic [WW-1:0]   row_base;

  assign accept    = (state_q == LOAD) && input_valid;
  assign load_done = accept && ld_last;
  assign issue     = (state_q == COMPUTE);
  assign out_hs    = (state_q == OUT) && output_ready;
  assign row_base  = WW'(row_cnt) * WW'(M);

  mod_counter #(.MOD(M)) u_ld (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (accept),
    .cnt   (ld_cnt),
    .last  (ld_last)
  );

  mod_counter #(.MOD(M)) u_col (
    .clk   (clk),
    .reset (reset),
    .clr   (load_done),
    .inc   (issue),
    .cnt   (col_cnt),
    .last  (col_last)
  );

  mod_counter #(.MOD(N)) u_row (
    .clk   (clk),
    .reset (reset),
    .clr   (load_done),
    .inc   (out_hs),
    .cnt   (row_cnt),
    .last  (row_last)
  );

  // en_acc lags the issue strobe to line up with the 1-cycle memory read latency.
  assign en_d   = issue;
  assign en_acc = en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done) state_d = COMPUTE;
      COMPUTE: if (col_last) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (output_ready) state_d = row_last ? LOAD : COMPUTE;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    input_ready  = 1'b0;
    output_valid = 1'b0;
    wr_en_x      = 1'b0;
    addr_x       = '0;
    addr_w       = '0;
    clear_acc    = 1'b0;
    case (state_q)
      LOAD: begin
        input_ready = 1'b1;
        wr_en_x     = input_valid;
        addr_x      = ld_cnt;
      end
      COMPUTE: begin
        addr_x    = col_cnt;
        addr_w    = row_base + WW'(col_cnt);
        clear_acc = (col_cnt == '0);
      end
      // col has already wrapped, so the last issued addresses are rebuilt from row.
      DRAIN, OUT: begin
        addr_x       = XW'(M - 1);
        addr_w       = row_base + WW'(M - 1);
        output_valid = (state_q == OUT);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: a behavioural vector memory / weight ROM / MAC driven by the DUT controls,
// with expected ReLU row results queued at stimulus time and popped by an output monitor.
module tb_fc_ctrl;

  localparam int M  = 8;
  localparam int N  = 16;
  localparam int NV = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       input_valid;
  logic       input_ready;
  logic       output_valid;
  logic       output_ready;
  logic       wr_en_x;
  logic [2:0] addr_x;
  logic [6:0] addr_w;
  logic       clear_acc;
  logic       en_acc;

  int input_data;
  int xmem [M];
  int x_rd, w_rd, acc;
  int vec  [M];
  int exp_q [$];
  int n_chk  = 0;
  int n_pass = 0;
  int aw_exp = 0;
  int prev_aw = 0;
  bit rand_or = 1'b0;

  fc_ctrl #(.M(M), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .wr_en_x      (wr_en_x),
    .addr_x       (addr_x),
    .addr_w       (addr_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc)
  );

  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return ((i * 37) % 61) - 30;
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Datapath around the controller: 1-cycle read latency memories and accumulator.
  always @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= input_data;
    x_rd <= xmem[addr_x];
    w_rd <= w_of(int'(addr_w));
    if (clear_acc) acc <= 0;
    else if (en_acc) acc <= acc + x_rd * w_rd;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp();
    for (int r = 0; r < N; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < M; c++) s += vec[c] * w_of(r * M + c);
      exp_q.push_back(relu(s));
    end
  endtask

  task automatic gen_vec();
    for (int c = 0; c < M; c++) vec[c] = int'($urandom_range(0, 200)) - 100;
  endtask

  task automatic feed_vec(input bit gaps);
    int k, cyc;
    k = 0;
    cyc = 0;
    while (k < M && cyc < 2000) begin
      input_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      input_data  = vec[k];
      @(negedge clk);
      if (!gaps) begin
        check("load_wr_en", int'(wr_en_x), 1);
        check("load_addr_x", int'(addr_x), k);
      end
      if (input_valid && input_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    input_valid = 1'b0;
    if (k < M) check("feed_timeout", k, M);
  endtask

  task automatic wait_hs(input int n);
    int hs, cyc;
    hs = 0;
    cyc = 0;
    while (hs < n && cyc < 2000) begin
      @(negedge clk);
      if (output_valid && output_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    check("handshake_count", hs, n);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_or) output_ready = ($urandom_range(0, 1) == 1);
  end

  // Output monitor: row results and the weight address stream behind each en_acc.
  initial forever begin
    @(negedge clk);
    if (!reset && output_valid && output_ready) begin
      if (exp_q.size() == 0) check("out_unexpected", relu(acc), -1);
      else check("out_data", relu(acc), exp_q.pop_front());
    end
    if (!reset && en_acc) begin
      check("addr_w_seq", prev_aw, aw_exp);
      aw_exp = (aw_exp + 1) % (M * N);
    end
    prev_aw = int'(addr_w);
  end

  initial begin
    int cyc;
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    input_data   = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_input_ready", int'(input_ready), 1);
    check("rst_output_valid", int'(output_valid), 0);
    check("rst_wr_en_x", int'(wr_en_x), 0);
    check("rst_clear_acc", int'(clear_acc), 0);
    check("rst_en_acc", int'(en_acc), 0);
    check("rst_addr_x", int'(addr_x), 0);
    check("rst_addr_w", int'(addr_w), 0);
    @(posedge clk); #1;

    // Back-to-back load, full compute timing, then a 20-cycle output stall.
    output_ready = 1'b0;
    for (int c = 0; c < M; c++) vec[c] = (c % 2 == 0) ? (c + 1) * 3 : -(c + 2);
    push_exp();
    feed_vec(1'b0);
    input_valid = 1'b1;
    for (int j = 0; j < M; j++) begin
      @(negedge clk);
      check("cmp_input_ready", int'(input_ready), 0);
      check("cmp_wr_en_x", int'(wr_en_x), 0);
      check("cmp_addr_x", int'(addr_x), j);
      check("cmp_addr_w", int'(addr_w), j);
      check("cmp_clear_acc", int'(clear_acc), (j == 0) ? 1 : 0);
      check("cmp_en_acc", int'(en_acc), (j == 0) ? 0 : 1);
      check("cmp_output_valid", int'(output_valid), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_en_acc", int'(en_acc), 1);
    check("drain_clear_acc", int'(clear_acc), 0);
    check("drain_output_valid", int'(output_valid), 0);
    @(posedge clk); #1;
    input_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("stall_output_valid", int'(output_valid), 1);
      check("stall_addr_w", int'(addr_w), 7);
      check("stall_en_acc", int'(en_acc), 0);
      check("stall_clear_acc", int'(clear_acc), 0);
      @(posedge clk); #1;
    end
    output_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("row1_addr_w", int'(addr_w), 8);
    check("row1_clear_acc", int'(clear_acc), 1);
    check("row1_output_valid", int'(output_valid), 0);
    @(posedge clk); #1;
    wait_hs(N - 1);
    @(negedge clk);
    check("layer_done_input_ready", int'(input_ready), 1);
    check("layer_done_output_valid", int'(output_valid), 0);
    @(posedge clk); #1;

    // Reset while computing row 3, column 4.
    for (int c = 0; c < M; c++) vec[c] = 50 - c * 11;
    push_exp();
    feed_vec(1'b0);
    wait_hs(3);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("midrst_pre_addr_x", int'(addr_x), 4);
    check("midrst_pre_addr_w", int'(addr_w), 28);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    aw_exp = 0;
    @(negedge clk);
    check("midrst_input_ready", int'(input_ready), 1);
    check("midrst_en_acc", int'(en_acc), 0);
    check("midrst_output_valid", int'(output_valid), 0);
    check("midrst_clear_acc", int'(clear_acc), 0);
    check("midrst_addr_w", int'(addr_w), 0);
    @(posedge clk); #1;

    // Random input and output gaps over several full layers.
    rand_or = 1'b1;
    for (int v = 0; v < NV; v++) begin
      gen_vec();
      push_exp();
      feed_vec(1'b1);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    rand_or = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
